answer_generator: RTL and testbench
===================================

Name: answer_generator

Overview:
- Sits directly downstream of the LCG random stage; consumes its 1..8 value stream.
- On a change_answer request, builds a game answer of DIGITS distinct digits, each in 1..MAX_VAL.
- Publishes the answer with a one-cycle write_enable pulse to the answer register / display logic.
- Rejects duplicates and out-of-range samples; a try-limit fallback guarantees termination even if the random stream locks into a short cycle.

Parameters:
DIGITS, 4, number of answer digits (must be <= MAX_VAL)
DIGIT_W, 4, bits per digit (MAX_VAL < 2**DIGIT_W)
MAX_VAL, 8, largest legal digit; legal range 1..MAX_VAL
MAX_TRIES, 16, consecutive rejected samples before fallback pick
FIXED_ANSWER, 16'h1234, answer loaded when ANSWER_FIXED_EN is defined

Ports:
clk  in  1  system clock
rst_n  in  1  reset
change_answer  in  1  request new answer (level from game control; rising edge acts)
rand_in  in  32  random stream from LCG stage; bits [DIGIT_W-1:0] used, upper bits ignored
answer  out  DIGITS*DIGIT_W  committed answer; slot 0 (first accepted digit) in MS nibble
answer_valid  out  1  answer holds a committed value
busy  out  1  collection in progress
write_enable  out  1  one-cycle pulse, answer updated this cycle

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: answer=0, answer_valid=0, busy=0, write_enable=0, state=IDLE, used mask=0, slot index=0, try counter=0, change_answer history register=0.
- Request: posedge where change_answer=1 and registered previous value=0.
- FSM IDLE:
  - On request -> COLLECT.
  - Clear used mask, index, tries and shadow register.
  - busy=1, answer_valid=0.
  - answer keeps its old value.
- FSM COLLECT, each posedge samples v=rand_in[DIGIT_W-1:0]:
  - Accept if 1<=v<=MAX_VAL and used[v]=0: shadow[index]=v, used[v]=1, index++, tries=0.
  - Reject otherwise, tries++.
  - Fallback: a reject with tries==MAX_TRIES-1 instead accepts the lowest unused value in 1..MAX_VAL, tries=0.
  - On the accept that fills slot DIGITS-1: answer<=shadow incl. this digit, answer_valid<=1, write_enable<=1 for exactly one cycle, busy<=0, -> IDLE.
- Latency: minimum DIGITS cycles from request edge to write_enable. Worst case DIGITS*MAX_TRIES.
- Request edges during COLLECT, or in the write_enable cycle, are ignored. A new rising edge is required to restart.
- change_answer held high generates exactly one answer.
- rst_n low mid-COLLECT: immediate return to reset values; partial digits discarded.
- Width rule: rand_in values >= 2**DIGIT_W cannot occur post-truncation. v=0 and v>MAX_VAL are always rejects.

Optional Feature:
- Macro: ANSWER_FIXED_EN.
- Defined: COLLECT is skipped; a request loads answer=FIXED_ANSWER on the next posedge with write_enable pulse and answer_valid=1. busy never asserts; rand_in is unused. Used for demos and display debug.
- Undefined: random collection as above; FIXED_ANSWER is unused.

Decomposition:
- Shared package answer_pkg holds:
  - state enum {IDLE, COLLECT}
  - DIGIT_W and MAX_VAL defaults
  - function for legality check 1<=v<=MAX_VAL
- One sub-module is natural: answer_fallback_enc, a combinational priority encoder. Input: used mask. Output: lowest unused value in 1..MAX_VAL.

Test Plan:
- Reset: pulse rst_n low asynchronously (between clock edges) -> answer=0, answer_valid=0, busy=0, write_enable=0 immediately.
- Clean draw: request, rand_in=3,5,7,2 on successive edges -> write_enable single pulse after 4th sample; answer=16'h3572, answer_valid=1, busy=0.
- Rejects: request, rand_in=3,3,0,9,5,5,1,8 -> duplicates/0/9 ignored; answer=16'h3518 after 8 samples.
- Stuck stream: request, rand_in held at 4, MAX_TRIES=16 -> digits 4, then 1 (after 16 rejects), then 2, then 3 -> answer=16'h4123.
- Request hygiene: change_answer held 100 cycles plus an extra pulse mid-COLLECT -> exactly one write_enable; a later fresh edge yields a second.
- Mid-operation reset: rst_n low after 2 accepted digits -> outputs reset; next request with 6,1,2,8 -> answer=16'h6128. With ANSWER_FIXED_EN: request -> answer=16'h1234 one cycle later.

Source files
------------

// File: rtl/answer_pkg.sv
// -----------------------------------------------------------------------------
// answer_pkg
// Shared types and helpers for the answer generator slice.
//   state_t      : collection FSM states
//   DIGIT_W_DEF  : default bits per digit
//   MAX_VAL_DEF  : default largest legal digit (legal range 1..MAX_VAL)
//   digit_legal  : true when 1 <= v <= max_val
// No ports (package).
// -----------------------------------------------------------------------------
package answer_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int DIGIT_W_DEF = 4;
    localparam int MAX_VAL_DEF = 8;

    function automatic logic digit_legal(input int v, input int max_val);
        return (v >= 1) && (v <= max_val);
    endfunction

endpackage

// File: rtl/answer_fallback_enc.sv
// -----------------------------------------------------------------------------
// answer_fallback_enc
// Combinational priority encoder: returns the lowest value in 1..MAX_VAL whose
// used bit is clear. Used when the random stream keeps producing rejects.
// Ports:
//   used [MAX_VAL:1]   in   values already taken by the answer under construction
//   pick [DIGIT_W-1:0] out  lowest unused value (0 only if every value is used)
// -----------------------------------------------------------------------------
module answer_fallback_enc
    import answer_pkg::*;
#(
    parameter int DIGIT_W = DIGIT_W_DEF,
    parameter int MAX_VAL = MAX_VAL_DEF
) (
    input  logic [MAX_VAL:1]   used,
    output logic [DIGIT_W-1:0] pick
);

    // Scan downwards so the last hit, i.e. the lowest free value, wins.
    always_comb begin
        pick = '0;
        for (int i = MAX_VAL; i >= 1; i--) begin
            if (!used[i]) pick = DIGIT_W'(i);
        end
    end

endmodule

// File: rtl/answer_generator.sv
// -----------------------------------------------------------------------------
// answer_generator
// Builds a game answer of DIGITS distinct digits (each 1..MAX_VAL) from the
// LCG random stream on a rising edge of change_answer, then publishes it with a
// one-cycle write_enable pulse. Duplicate and out-of-range samples are rejected;
// after MAX_TRIES consecutive rejects the lowest unused value is taken instead,
// so collection always terminates.
//
// Optional build macro ANSWER_FIXED_EN: a request loads FIXED_ANSWER directly
// (write_enable pulse, answer_valid=1, busy never asserts, rand_in unused).
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   change_answer in   request level; its rising edge starts a new answer
//   rand_in [31:0] in  random stream; only bits [DIGIT_W-1:0] are used
//   answer        out  committed answer, first accepted digit in the MS nibble
//   answer_valid  out  answer holds a committed value
//   busy          out  collection in progress
//   write_enable  out  one-cycle pulse in the cycle answer is updated
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a request edge; answer holds last committed value
// COLLECT | sampling rand_in every cycle until DIGITS digits are accepted
// -----------------------------------------------------------------------------
module answer_generator
    import answer_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DIGIT_W   = DIGIT_W_DEF,
    parameter int MAX_VAL   = MAX_VAL_DEF,
    parameter int MAX_TRIES = 16,
    parameter logic [DIGITS*DIGIT_W-1:0] FIXED_ANSWER = 16'h1234
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        change_answer,
    input  logic [31:0]                 rand_in,
    output logic [DIGITS*DIGIT_W-1:0]   answer,
    output logic                        answer_valid,
    output logic                        busy,
    output logic                        write_enable
);

    localparam int IDX_W = $clog2(DIGITS + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    state_t                           state_q, state_d;
    logic                             chg_q;
    logic                             req, start;
    logic [DIGIT_W-1:0]               v;
    logic [MAX_VAL:1]                 used_q;
    logic                             used_hit;
    logic [IDX_W-1:0]                 idx_q;
    logic [TRY_W-1:0]                 tries_q;
    logic [DIGITS-1:0][DIGIT_W-1:0]   shadow_q, shadow_d;
    logic [DIGIT_W-1:0]               fb_pick, digit;
    logic                             is_new, fallback, accept, last;
    logic                             unused_bits;

    assign unused_bits = ^{FIXED_ANSWER, rand_in[31:DIGIT_W]};

    // Requests are ignored while collecting and in the write_enable cycle.
    assign req   = change_answer & ~chg_q;
    assign start = req & (state_q == IDLE) & ~write_enable;

    assign v = rand_in[DIGIT_W-1:0];

    always_comb begin
        used_hit = 1'b0;
        for (int i = 1; i <= MAX_VAL; i++) begin
            if (int'(v) == i) used_hit = used_q[i];
        end
    end

    answer_fallback_enc #(
        .DIGIT_W (DIGIT_W),
        .MAX_VAL (MAX_VAL)
    ) u_fallback (
        .used (used_q),
        .pick (fb_pick)
    );

    assign is_new   = digit_legal(int'(v), MAX_VAL) && !used_hit;
    assign fallback = !is_new && (tries_q == TRY_W'(MAX_TRIES - 1));
    assign accept   = is_new || fallback;
    assign digit    = is_new ? v : fb_pick;
    assign last     = accept && (idx_q == IDX_W'(DIGITS - 1));

    // Slot 0 lives in the MS digit of the packed shadow.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) shadow_d[DIGITS-1-i] = digit;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifndef ANSWER_FIXED_EN
                if (start) state_d = COLLECT;
`endif
            end
            COLLECT: begin
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= change_answer;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q       <= '0;
            idx_q        <= '0;
            tries_q      <= '0;
            shadow_q     <= '0;
            answer       <= '0;
            answer_valid <= 1'b0;
            write_enable <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            if (start) begin
`ifdef ANSWER_FIXED_EN
                answer       <= FIXED_ANSWER;
                answer_valid <= 1'b1;
                write_enable <= 1'b1;
`else
                used_q       <= '0;
                idx_q        <= '0;
                tries_q      <= '0;
                shadow_q     <= '0;
                answer_valid <= 1'b0;
`endif
            end else if (state_q == COLLECT) begin
                if (accept) begin
                    for (int i = 1; i <= MAX_VAL; i++) begin
                        if (int'(digit) == i) used_q[i] <= 1'b1;
                    end
                    shadow_q <= shadow_d;
                    tries_q  <= '0;
                    if (last) begin
                        answer       <= shadow_d;
                        answer_valid <= 1'b1;
                        write_enable <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end else begin
                    tries_q <= tries_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_answer_generator.sv
module tb_answer_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        change_answer = 1'b0;
    logic [31:0] rand_in = '0;
    logic [15:0] answer;
    logic        answer_valid, busy, write_enable;

    int checks = 0;
    int errors = 0;

    answer_generator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .change_answer (change_answer),
        .rand_in       (rand_in),
        .answer        (answer),
        .answer_valid  (answer_valid),
        .busy          (busy),
        .write_enable  (write_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit seen(input int a[$], input int v);
        foreach (a[i]) if (a[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lowest_missing(input int a[$]);
        for (int c = 1; c <= 8; c++) if (!seen(a, c)) return c;
        return 0;
    endfunction

    // Reference: walk the sample list, keep the accepted digits in a queue;
    // the 16th reject in a row is replaced by the smallest digit not yet taken.
    function automatic void model(input logic [31:0] s[$], output logic [15:0] ans, output int n);
        int acc[$];
        int rejects;
        int v;
        rejects = 0;
        n = 0;
        ans = '0;
        while (acc.size() < 4 && n < s.size()) begin
            v = int'(s[n] % 32'd16);
            n++;
            if (v >= 1 && v <= 8 && !seen(acc, v)) begin
                acc.push_back(v);
                rejects = 0;
            end else begin
                rejects++;
                if (rejects == 16) begin
                    acc.push_back(lowest_missing(acc));
                    rejects = 0;
                end
            end
        end
        foreach (acc[i]) ans = (ans << 4) | 16'(acc[i]);
    endfunction

    // Raise change_answer, feed the samples the model says are consumed, and
    // check the publish cycle. Leaves change_answer high.
    task automatic draw(input logic [31:0] s[$], input bit extra_pulse,
                        input bit edge_at_we, input string tag);
        logic [15:0] exp_ans;
        int n;
        int early;
        model(s, exp_ans, n);
        @(negedge clk);
        change_answer = 1'b1;
        rand_in = $urandom();
        @(negedge clk);
        check({tag, " busy_start"}, 32'(busy), 32'd1);
        check({tag, " valid_start"}, 32'(answer_valid), 32'd0);
        early = 0;
        for (int k = 0; k < n; k++) begin
            rand_in = s[k];
            if (extra_pulse && k == 1) change_answer = 1'b0;
            if (extra_pulse && k == 2) change_answer = 1'b1;
            if (edge_at_we && k == n - 1) change_answer = 1'b0;
            @(negedge clk);
            if (k < n - 1 && write_enable) early++;
        end
        check({tag, " early_we"}, 32'(early), 32'd0);
        check({tag, " we"}, 32'(write_enable), 32'd1);
        check({tag, " answer"}, 32'(answer), 32'(exp_ans));
        check({tag, " valid"}, 32'(answer_valid), 32'd1);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        if (edge_at_we) change_answer = 1'b1;
        rand_in = $urandom();
        @(negedge clk);
        check({tag, " we_off"}, 32'(write_enable), 32'd0);
        check({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic release_req();
        @(negedge clk);
        change_answer = 1'b0;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        logic [31:0] q[$];
        int extra;
        int busy_seen;

        // Power-on reset
        #12;
        check("por answer", 32'(answer), 32'd0);
        check("por valid", 32'(answer_valid), 32'd0);
        check("por busy", 32'(busy), 32'd0);
        check("por we", 32'(write_enable), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        q = {32'd3, 32'd5, 32'd7, 32'd2};
        draw(q, 1'b0, 1'b0, "clean");
        check("clean literal", 32'(answer), 32'h3572);
        release_req();

        q = {32'd3, 32'd3, 32'd0, 32'd9, 32'd5, 32'd5, 32'd1, 32'd8};
        draw(q, 1'b0, 1'b0, "rejects");
        check("rejects literal", 32'(answer), 32'h3518);
        release_req();

        q = {};
        for (int i = 0; i < 60; i++) q.push_back(32'hABCD_0004);
        draw(q, 1'b0, 1'b0, "stuck");
        check("stuck literal", 32'(answer), 32'h4123);
        release_req();

        // Held level plus a spurious edge mid-collection: one answer only.
        q = {};
        for (int i = 0; i < 200; i++) q.push_back($urandom());
        draw(q, 1'b1, 1'b0, "hygiene");
        extra = 0;
        busy_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (write_enable) extra++;
            if (busy) busy_seen++;
        end
        check("hygiene extra_we", 32'(extra), 32'd0);
        check("hygiene extra_busy", 32'(busy_seen), 32'd0);
        release_req();
        q = {};
        for (int i = 0; i < 200; i++) q.push_back($urandom());
        draw(q, 1'b0, 1'b0, "hygiene second");
        release_req();

        // Fresh edge landing in the write_enable cycle is ignored.
        q = {32'd8, 32'd7, 32'd6, 32'd5};
        draw(q, 1'b0, 1'b1, "edge_at_we");
        busy_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || write_enable) busy_seen++;
        end
        check("edge_at_we ignored", 32'(busy_seen), 32'd0);
        release_req();

        // Randomized draws: half full-range, half narrow streams that force fallbacks.
        for (int t = 0; t < 20; t++) begin
            q = {};
            for (int i = 0; i < 200; i++) begin
                if (t % 2 == 0) q.push_back($urandom());
                else q.push_back(($urandom() & 32'hFFFF_FFF0) | 32'($urandom_range(0, 3)));
            end
            draw(q, 1'b0, 1'b0, $sformatf("rand%0d", t));
            release_req();
        end

        // Async reset after two accepted digits.
        @(negedge clk);
        change_answer = 1'b1;
        @(negedge clk);
        rand_in = 32'd3;
        @(negedge clk);
        rand_in = 32'd5;
        @(negedge clk);
        rand_in = 32'd7;
        #2;
        rst_n = 1'b0;
        change_answer = 1'b0;
        #1;
        check("midrst answer", 32'(answer), 32'd0);
        check("midrst valid", 32'(answer_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst we", 32'(write_enable), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst idle", 32'(busy), 32'd0);
        q = {32'd6, 32'd1, 32'd2, 32'd8};
        draw(q, 1'b0, 1'b0, "after_rst");
        check("after_rst literal", 32'(answer), 32'h6128);
        release_req();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
